// File: rtl/pc_seq_pkg.sv
// Shared types and constants for the program-counter sequencer.
//   seq_state_t  : sequencer FSM states (RUN, DRAIN, HALTED)
//   FAULT_*      : encodings of the sticky fault_code output
//   PC_STEP      : byte increment for sequential fetch
//   fault_classify : maps the two illegal-target conditions onto a fault code
package pc_seq_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } seq_state_t;

  localparam logic [1:0] FAULT_NONE     = 2'd0;
  localparam logic [1:0] FAULT_MISALIGN = 2'd1;
  localparam logic [1:0] FAULT_RANGE    = 2'd2;
  localparam logic [1:0] FAULT_BOTH     = 2'd3;

  localparam int unsigned PC_STEP = 4;

  function automatic logic [1:0] fault_classify(input logic misalign, input logic range);
    logic [1:0] code;
    case ({range, misalign})
      2'b01:   code = FAULT_MISALIGN;
      2'b10:   code = FAULT_RANGE;
      2'b11:   code = FAULT_BOTH;
      default: code = FAULT_NONE;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/pc_sequencer.sv
// Program counter and fetch sequencer for the pipelined core.
// Chooses each cycle between sequential advance, stall-hold and execute-stage
// redirect, raises the IF/ID and ID/EX flushes a redirect needs, runs a fixed
// drain on halt (or on an illegal redirect target) and then reports halted.
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   stall               : hold pc (and IF/ID) this cycle
//   PcSel, BrPC         : redirect taken / redirect target
//   halt                : instruction in EX is a halt
//   pc, if_valid        : registered fetch address / fetch is a real instruction
//   flush_ifid/idex     : squash pipeline registers at the next edge
//   halted              : pipeline drained (registered)
//   fault, fault_code   : sticky illegal-redirect flag and its cause
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int unsigned       PC_W         = 9,
  parameter logic [PC_W-1:0]   RESET_PC     = '0,
  parameter int unsigned       DRAIN_CYCLES = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            PcSel,
  input  logic [31:0]     BrPC,
  input  logic            halt,
  output logic [PC_W-1:0] pc,
  output logic            if_valid,
  output logic            flush_ifid,
  output logic            flush_idex,
  output logic            halted,
  output logic            fault,
  output logic [1:0]      fault_code
);

  localparam int unsigned    CntW    = $clog2(DRAIN_CYCLES + 1);
  localparam logic [CntW-1:0] CntInit = CntW'(DRAIN_CYCLES - 1);

  seq_state_t      state_q;
  logic [CntW-1:0] cnt_q;
  logic [PC_W-1:0] pc_q;
  logic            halted_q;
  logic            fault_q;
  logic [1:0]      fault_code_q;

  logic misalign, range, illegal;

  assign misalign = |BrPC[1:0];
  assign range    = |BrPC[31:PC_W];
  assign illegal  = PcSel && (misalign || range);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= RUN;
      cnt_q        <= '0;
      pc_q         <= RESET_PC;
      halted_q     <= 1'b0;
      fault_q      <= 1'b0;
      fault_code_q <= FAULT_NONE;
    end else begin
      case (state_q)
        RUN: begin
          if (halt) begin
            state_q <= DRAIN;
            cnt_q   <= CntInit;
          end else if (illegal) begin
            // Trap: the bad target is never loaded; drain as for a halt.
            if (!fault_q) begin
              fault_q      <= 1'b1;
              fault_code_q <= fault_classify(misalign, range);
            end
            state_q <= DRAIN;
            cnt_q   <= CntInit;
          end else if (PcSel) begin
            pc_q <= BrPC[PC_W-1:0];
          end else if (!stall) begin
            pc_q <= pc_q + PC_W'(PC_STEP);
          end
        end
        DRAIN: begin
          if (cnt_q == '0) begin
            state_q  <= HALTED;
            halted_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        HALTED: ;
        default: state_q <= RUN;
      endcase
    end
  end

  // Outside RUN fetch is dead and both pipeline registers are held squashed.
  always_comb begin
    if_valid   = 1'b0;
    flush_ifid = 1'b1;
    flush_idex = 1'b1;
    if (state_q == RUN) begin
      if_valid   = 1'b1;
      flush_ifid = PcSel | halt;
      flush_idex = PcSel | halt;
    end
  end

  assign pc         = pc_q;
  assign halted     = halted_q;
  assign fault      = fault_q;
  assign fault_code = fault_code_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: each driven cycle pushes the outputs
// expected during that cycle; a monitor pops and compares mid-cycle.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        reset, stall, PcSel, halt;
  logic [31:0] BrPC;
  logic [8:0]  pc;
  logic        if_valid, flush_ifid, flush_idex, halted, fault;
  logic [1:0]  fault_code;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    string      tag;
    logic [8:0] pc;
    logic       iv;
    logic       fl;
    logic       ck_fl;
    logic       hlt;
    logic       flt;
    logic [1:0] code;
  } exp_t;

  exp_t exp_q[$];

  pc_sequencer #(
    .PC_W        (9),
    .RESET_PC    (9'd0),
    .DRAIN_CYCLES(2)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .stall     (stall),
    .PcSel     (PcSel),
    .BrPC      (BrPC),
    .halt      (halt),
    .pc        (pc),
    .if_valid  (if_valid),
    .flush_ifid(flush_ifid),
    .flush_idex(flush_idex),
    .halted    (halted),
    .fault     (fault),
    .fault_code(fault_code)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, want);
    end
  endtask

  // Monitor: inputs change right after negedge, outputs sampled 2 units later.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      while (exp_q.size() > 0) begin
        exp_t e;
        e = exp_q.pop_front();
        check_eq({e.tag, ".pc"},       32'(pc),         32'(e.pc));
        check_eq({e.tag, ".if_valid"}, 32'(if_valid),   32'(e.iv));
        check_eq({e.tag, ".halted"},   32'(halted),     32'(e.hlt));
        check_eq({e.tag, ".fault"},    32'(fault),      32'(e.flt));
        check_eq({e.tag, ".code"},     32'(fault_code), 32'(e.code));
        if (e.ck_fl) begin
          check_eq({e.tag, ".flush_ifid"}, 32'(flush_ifid), 32'(e.fl));
          check_eq({e.tag, ".flush_idex"}, 32'(flush_idex), 32'(e.fl));
        end
      end
    end
  end

  // Drive one cycle of inputs and queue the outputs expected during it.
  task automatic step(input string tag, input logic rst, input logic st, input logic sel,
                      input logic [31:0] br, input logic hl,
                      input logic [8:0] e_pc, input logic e_iv, input logic e_fl,
                      input logic e_hlt, input logic e_flt, input logic [1:0] e_code);
    exp_t e;
    @(negedge clk);
    reset = rst;
    stall = st;
    PcSel = sel;
    BrPC  = br;
    halt  = hl;
    e.tag   = tag;
    e.pc    = e_pc;
    e.iv    = e_iv;
    e.fl    = e_fl;
    e.ck_fl = !rst;
    e.hlt   = e_hlt;
    e.flt   = e_flt;
    e.code  = e_code;
    exp_q.push_back(e);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    stall = 1'b0;
    PcSel = 1'b0;
    BrPC  = '0;
    halt  = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    stall = 1'b0;
    PcSel = 1'b0;
    BrPC  = '0;
    halt  = 1'b0;
    do_reset();
    do_reset();

    // Sequential fetch from reset
    step("rst_state", 0, 0, 0, 0, 0, 9'd0, 1, 0, 0, 0, 2'd0);
    for (int i = 1; i <= 6; i++)
      step("seq", 0, 0, 0, 0, 0, 9'(4 * i), 1, 0, 0, 0, 2'd0);
    // pc now 28: redirect beats stall
    step("redir_stall", 0, 1, 1, 32'h40, 0, 9'd28, 1, 1, 0, 0, 2'd0);
    step("redir_tgt", 0, 0, 0, 0, 0, 9'h40, 1, 0, 0, 0, 2'd0);
    step("stall_hold", 0, 1, 0, 0, 0, 9'h44, 1, 0, 0, 0, 2'd0);
    // Wrap: 508 -> 0
    step("to_508", 0, 0, 1, 32'd508, 0, 9'h44, 1, 1, 0, 0, 2'd0);
    step("at_508", 0, 0, 0, 0, 0, 9'd508, 1, 0, 0, 0, 2'd0);
    step("wrap0", 0, 0, 0, 0, 0, 9'd0, 1, 0, 0, 0, 2'd0);
    step("wrap4", 0, 0, 0, 0, 0, 9'd4, 1, 0, 0, 0, 2'd0);
    // Halt at 0x20, redirect pulses during drain are ignored
    step("to_20", 0, 0, 1, 32'h20, 0, 9'd8, 1, 1, 0, 0, 2'd0);
    step("halt", 0, 0, 0, 0, 1, 9'h20, 1, 1, 0, 0, 2'd0);
    step("drain1", 0, 0, 1, 32'h80, 0, 9'h20, 0, 1, 0, 0, 2'd0);
    step("drain2", 0, 1, 1, 32'h84, 1, 9'h20, 0, 1, 0, 0, 2'd0);
    step("halted", 0, 0, 0, 0, 0, 9'h20, 0, 1, 1, 0, 2'd0);
    step("halted_hold", 0, 0, 1, 32'h40, 0, 9'h20, 0, 1, 1, 0, 2'd0);

    // Misaligned target
    do_reset();
    step("mis_rst", 0, 0, 0, 0, 0, 9'd0, 1, 0, 0, 0, 2'd0);
    step("mis_req", 0, 0, 1, 32'h42, 0, 9'd4, 1, 1, 0, 0, 2'd0);
    step("mis_d1", 0, 0, 1, 32'h1000, 0, 9'd4, 0, 1, 0, 1, 2'd1);
    step("mis_d2", 0, 0, 0, 0, 0, 9'd4, 0, 1, 0, 1, 2'd1);
    step("mis_hlt", 0, 0, 0, 0, 0, 9'd4, 0, 1, 1, 1, 2'd1);

    // Out of range target
    do_reset();
    step("rng_rst", 0, 0, 0, 0, 0, 9'd0, 1, 0, 0, 0, 2'd0);
    step("rng_req", 0, 1, 1, 32'h1000, 0, 9'd4, 1, 1, 0, 0, 2'd0);
    step("rng_d1", 0, 0, 0, 0, 0, 9'd4, 0, 1, 0, 1, 2'd2);

    // Both
    do_reset();
    step("both_rst", 0, 0, 0, 0, 0, 9'd0, 1, 0, 0, 0, 2'd0);
    step("both_req", 0, 0, 1, 32'h1002, 0, 9'd4, 1, 1, 0, 0, 2'd0);
    step("both_d1", 0, 0, 0, 0, 0, 9'd4, 0, 1, 0, 1, 2'd3);

    // Halt wins over simultaneous redirect
    do_reset();
    step("hr_rst", 0, 0, 0, 0, 0, 9'd0, 1, 0, 0, 0, 2'd0);
    step("hr_req", 0, 0, 1, 32'h80, 1, 9'd4, 1, 1, 0, 0, 2'd0);
    step("hr_d1", 0, 0, 0, 0, 0, 9'd4, 0, 1, 0, 0, 2'd0);
    step("hr_d2", 0, 0, 0, 0, 0, 9'd4, 0, 1, 0, 0, 2'd0);
    step("hr_hlt", 0, 0, 0, 0, 0, 9'd4, 0, 1, 1, 0, 2'd0);

    // Reset mid-drain (after a fault, so fault clearing is visible)
    do_reset();
    step("rd_rst", 0, 0, 0, 0, 0, 9'd0, 1, 0, 0, 0, 2'd0);
    step("rd_fault", 0, 0, 1, 32'h41, 0, 9'd4, 1, 1, 0, 0, 2'd0);
    step("rd_d1", 1, 0, 0, 0, 0, 9'd4, 0, 1, 0, 1, 2'd1);
    step("rd_after", 0, 0, 0, 0, 0, 9'd0, 1, 0, 0, 0, 2'd0);
    step("rd_run4", 0, 0, 0, 0, 0, 9'd4, 1, 0, 0, 0, 2'd0);
    step("rd_run8", 0, 0, 0, 0, 0, 9'd8, 1, 0, 0, 0, 2'd0);

    @(negedge clk);
    #4;
    check_eq("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Owns the program counter of the pipelined RISC-V core and sequences instruction fetch around it. Each cycle it chooses between sequential advance, stall-hold and branch/jump redirect from the execute-stage branch unit, and raises the IF/ID and ID/EX flushes a taken redirect needs. It replaces ad-hoc simulation-stop logic with a clean halt sequence: it stops fetch, drains the in-flight instructions for a fixed number of cycles, then asserts `halted`. It also traps illegal redirect targets.

## Interface
- `PC_W`, 9, width of the PC register and of the instruction-memory address.
- `RESET_PC`, 0, PC value loaded on reset, PC_W bits.
- `DRAIN_CYCLES`, 2, cycles after the halting instruction leaves EX until it has retired (MEM, WB). Legal range 1..15.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `stall` in 1: hazard unit requests that PC and IF/ID hold.
- `PcSel` in 1: execute-stage branch unit, redirect taken.
- `BrPC` in 32: redirect target. Only valid when `PcSel`=1.
- `halt` in 1: the instruction in EX is a halt.
- `pc` out PC_W: current fetch address, registered.
- `if_valid` out 1: fetch at `pc` is a real instruction (0 = bubble).
- `flush_ifid` out 1: squash the IF/ID register at the next edge.
- `flush_idex` out 1: squash the ID/EX register at the next edge.
- `halted` out 1: pipeline fully drained, registered.
- `fault` out 1: sticky, an illegal redirect occurred.
- `fault_code` out 2: 0 none, 1 misaligned (`BrPC[1:0]`≠0), 2 out of range (`BrPC[31:PC_W]`≠0), 3 both. Latched with `fault`.

## Operation
- FSM states are RUN, DRAIN and HALTED. Reset enters RUN.
- Reset values: `pc`=RESET_PC, `halted`=0, `fault`=0, `fault_code`=0, drain counter 0.
- Redirect is illegal when `PcSel`=1 and `BrPC[1:0]`≠0, or when any of `BrPC[31:PC_W]` is nonzero.
- RUN, evaluated in this priority order:
  - halt: `halt`=1 goes to DRAIN. The counter loads DRAIN_CYCLES-1 and `pc` holds. `halt` wins over a simultaneous `PcSel` or `stall`.
  - illegal redirect: set `fault` and latch `fault_code`, then enter DRAIN exactly as for halt. The target is not loaded.
  - legal redirect: `pc` takes `BrPC[PC_W-1:0]`. This wins over `stall`.
  - stall: `pc` holds.
  - otherwise: `pc` takes `pc`+4, modulo 2^PC_W (wraps silently to 0).
- Outputs in RUN are combinational from the current inputs:
  - `flush_ifid` = `flush_idex` = `PcSel` OR `halt`.
  - `if_valid` = 1.
- DRAIN:
  - `pc` frozen, `if_valid`=0, `flush_ifid`=1, `flush_idex`=1.
  - Inputs `stall`, `PcSel` and `halt` are ignored.
  - The counter decrements each cycle. When it reaches 0, move to HALTED on that edge.
- HALTED:
  - `halted`=1, `pc` frozen, `if_valid`=0, both flushes=1.
  - Only `reset` leaves this state.
- `fault` and `fault_code` hold until reset. A second fault never overwrites them.

## Timing
- Redirect seen in cycle t gives the new `pc` at t+1. The flushes are asserted during cycle t.
- Halt seen in cycle t: DRAIN occupies t+1 .. t+DRAIN_CYCLES, and `halted` rises at t+DRAIN_CYCLES+1.
- Reset asserted in any state, including mid-DRAIN, takes effect at the next edge with all outputs at their reset values. Flush outputs during a reset cycle are don't-care.
- No combinational path from `BrPC` to `halted` or `fault`. Both are registered.

## Structure
- Package `pc_seq_pkg` holds:
  - typedef `seq_state_t` with values RUN, DRAIN, HALTED;
  - fault-code localparams FAULT_NONE, FAULT_MISALIGN, FAULT_RANGE, FAULT_BOTH;
  - constant PC_STEP = 4.
- Single flat module. The drain counter is `$clog2(DRAIN_CYCLES+1)` bits inline, with no sub-module.

## Test plan
- Sequential fetch: reset, then 5 free cycles. `pc` goes 0, 4, 8, 12, 16, 20. With PC_W=9, starting at 508, the next `pc` is 0.
- Redirect over stall: `stall`=1, `PcSel`=1, `BrPC`=0x40 in the same cycle. `flush_ifid`=`flush_idex`=1 that cycle and `pc`=0x40 the next.
- Halt drain: `halt` at `pc`=0x20. `if_valid`=0 for 2 cycles, `halted`=1 on the 3rd cycle after, `pc` stays 0x20. `PcSel` pulses during DRAIN are ignored.
- Misaligned target: `PcSel`=1, `BrPC`=0x42. Next cycle `fault`=1, `fault_code`=1, `pc` unchanged, state DRAIN. `BrPC`=0x1000 gives `fault_code`=2, and 0x1002 gives 3.
- Halt plus redirect: `halt`=1 and `PcSel`=1, `BrPC`=0x80. `pc` does not become 0x80 and the DRAIN sequence follows.
- Reset mid-DRAIN: `reset` one cycle into DRAIN. Next cycle `pc`=RESET_PC, `halted`=0, `fault`=0, and normal fetch resumes.
